// File: rtl/even_parity_frame_rx.sv
// Serial receiver for start / DATA_W data (LSB first) / even parity / stop frames.
// One bit per clk when bit_en is high; delivers the word with parity/framing flags and a saturating error count.
module even_parity_frame_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 din,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shreg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_par;
  logic                r_perr;
  logic                r_stop;
  logic                r_upd;

  logic                w_last_bit;
  logic                w_frame_bad;
  logic                w_err_sat;

  assign w_last_bit  = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_frame_bad = r_perr | ~r_stop;
  assign w_err_sat   = &err_cnt;

  // Receive FSM: advances only on bit_en; r_upd requests the output update one edge after the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_stop  <= 1'b0;
      r_upd   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!din) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              r_par   <= 1'b0;
              busy    <= 1'b1;
            end
          end
          S_DATA: begin
            r_shreg <= {din, r_shreg[DATA_W-1:1]};
            r_par   <= r_par ^ din;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last_bit) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_perr  <= r_par ^ din;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_stop  <= din;
            r_upd   <= 1'b1;
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output update is independent of bit_en, so the valid pulse always lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= r_upd;
      if (r_upd) begin
        dout       <= r_shreg;
        parity_err <= r_perr;
        frame_err  <= ~r_stop;
      end
    end
  end

  // Saturating error count; a clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (r_upd && w_frame_bad && !w_err_sat) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
